// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use comparator: a load in EX feeding a source of the ID instruction.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       ex_memRead,
    input  logic [4:0] ex_RegRd,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    output logic       load_use
);

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign load_use = ex_memRead && (ex_RegRd != REG_X0) &&
                      ((ex_RegRd == id_rs1) || (ex_RegRd == id_rs2));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             ex_memRead,
    input  logic [4:0]       ex_RegRd,
    input  logic             ex_branch_taken,
    input  logic             ex_jump,
    input  logic             mem_memRead,
    input  logic             mem_memWrite,
    input  logic             dmem_ready,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             mem_wb_flush,
    output logic             pc_redirect,
    output logic             dmem_req,
    output logic             timeout_err,
    output logic [CNT_W-1:0] perf_stall_cycles,
    output logic [CNT_W-1:0] perf_flushes
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

    state_t        state, state_n;
    logic [CW-1:0] wait_cnt, wait_cnt_n;
    logic          timeout_err_n;
    logic          mem_acc;
    logic          mem_wait;
    logic          load_use;

    hazard_detect u_hazard_detect (
        .ex_memRead (ex_memRead),
        .ex_RegRd   (ex_RegRd),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .load_use   (load_use)
    );

    assign mem_acc  = mem_memRead | mem_memWrite;
    assign mem_wait = mem_acc & ~dmem_ready & (state != ERROR);
    assign dmem_req = mem_acc & (state != ERROR);

    always_comb begin
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_stall   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_stall  = 1'b0;
        mem_wb_flush  = 1'b0;
        pc_redirect   = 1'b0;
        state_n       = state;
        wait_cnt_n    = wait_cnt;
        timeout_err_n = timeout_err;

        if (state == ERROR) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (mem_wait) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_flush = 1'b1;
            // The TIMEOUT-th consecutive stall cycle is the last before the lock.
            if (wait_cnt == LAST_WAIT) begin
                state_n       = ERROR;
                timeout_err_n = 1'b1;
            end else begin
                state_n    = MEM_WAIT;
                wait_cnt_n = wait_cnt + 1'b1;
            end
        end else begin
            state_n    = RUN;
            wait_cnt_n = '0;
            // A redirect squashes the ID instruction, so any load-use on it is moot.
            if (ex_branch_taken | ex_jump) begin
                pc_redirect = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            wait_cnt    <= wait_cnt_n;
            timeout_err <= timeout_err_n;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_flushes      <= '0;
        end else begin
            if (pc_stall)
                perf_stall_cycles <= perf_stall_cycles + 1'b1;
            if (pc_redirect)
                perf_flushes <= perf_flushes + 1'b1;
        end
    end
`else
    assign perf_stall_cycles = '0;
    assign perf_flushes      = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

    localparam int TMO   = 4;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_rs1, id_rs2, ex_RegRd;
    logic             ex_memRead, ex_branch_taken, ex_jump;
    logic             mem_memRead, mem_memWrite, dmem_ready;
    logic             pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic             ex_mem_stall, mem_wb_flush, pc_redirect, dmem_req, timeout_err;
    logic [CNT_W-1:0] perf_stall_cycles, perf_flushes;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model state: consecutive not-ready cycles, lock flag, event counts.
    int unsigned m_waits  = 0;
    bit          m_locked = 1'b0;
    int unsigned m_stalls = 0;
    int unsigned m_flush  = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .id_rs1            (id_rs1),
        .id_rs2            (id_rs2),
        .ex_memRead        (ex_memRead),
        .ex_RegRd          (ex_RegRd),
        .ex_branch_taken   (ex_branch_taken),
        .ex_jump           (ex_jump),
        .mem_memRead       (mem_memRead),
        .mem_memWrite      (mem_memWrite),
        .dmem_ready        (dmem_ready),
        .pc_stall          (pc_stall),
        .if_id_stall       (if_id_stall),
        .if_id_flush       (if_id_flush),
        .id_ex_stall       (id_ex_stall),
        .id_ex_flush       (id_ex_flush),
        .ex_mem_stall      (ex_mem_stall),
        .mem_wb_flush      (mem_wb_flush),
        .pc_redirect       (pc_redirect),
        .dmem_req          (dmem_req),
        .timeout_err       (timeout_err),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flushes      (perf_flushes)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bit order: pc_stall if_id_stall if_id_flush id_ex_stall id_ex_flush
    //            ex_mem_stall mem_wb_flush pc_redirect dmem_req timeout_err
    function automatic logic [9:0] dut_ctrl();
        return {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                ex_mem_stall, mem_wb_flush, pc_redirect, dmem_req, timeout_err};
    endfunction

    function automatic logic [9:0] model_ctrl();
        bit acc, lu;
        acc = mem_memRead || mem_memWrite;
        lu  = ex_memRead && ex_RegRd != 0 && (ex_RegRd == id_rs1 || ex_RegRd == id_rs2);
        if (m_locked)
            return 10'b11_0_1_0_1_1_0_0_1;
        if (acc && !dmem_ready)
            return {7'b11_0_1_0_1_1, 1'b0, 1'b1, 1'b0};
        if (ex_branch_taken || ex_jump)
            return {7'b00_1_0_1_0_0, 1'b1, acc, 1'b0};
        if (lu)
            return {7'b11_0_0_1_0_0, 1'b0, acc, 1'b0};
        return {9'b0, acc} << 1;
    endfunction

    // One clock: drive inputs after the falling edge, compare, then advance the model.
    task automatic step(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic ld, input logic [4:0] rd, input logic br, input logic jmp,
                        input logic mrd, input logic mwr, input logic rdy);
        logic [9:0] exp;
        @(negedge clk);
        rst = r; id_rs1 = rs1; id_rs2 = rs2; ex_memRead = ld; ex_RegRd = rd;
        ex_branch_taken = br; ex_jump = jmp; mem_memRead = mrd; mem_memWrite = mwr;
        dmem_ready = rdy;
        #1;
        exp = model_ctrl();
        check("ctrl", 32'(dut_ctrl()), 32'(exp));
`ifdef PIPE_CTRL_PERF_EN
        check("perf_stall", perf_stall_cycles, m_stalls);
        check("perf_flush", perf_flushes, m_flush);
`else
        check("perf_stall_off", perf_stall_cycles, 32'd0);
        check("perf_flush_off", perf_flushes, 32'd0);
`endif
        @(posedge clk);
        if (r) begin
            m_waits = 0; m_locked = 1'b0; m_stalls = 0; m_flush = 0;
        end else begin
            if (exp[9]) m_stalls++;
            if (exp[2]) m_flush++;
            if (!m_locked) begin
                if ((mrd || mwr) && !rdy) begin
                    m_waits++;
                    if (m_waits == TMO) m_locked = 1'b1;
                end else begin
                    m_waits = 0;
                end
            end
        end
    endtask

    task automatic idle(input logic r);
        step(r, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        int unsigned slow;
        rst = 1'b1; id_rs1 = '0; id_rs2 = '0; ex_memRead = 1'b0; ex_RegRd = '0;
        ex_branch_taken = 1'b0; ex_jump = 1'b0; mem_memRead = 1'b0; mem_memWrite = 1'b0;
        dmem_ready = 1'b1;
        @(posedge clk);
        idle(1'b1);
        idle(1'b0);
        check("reset_ctrl", 32'(dut_ctrl()), 32'd0);

        // Load-use on rs2, then the load moves to MEM and the hazard clears.
        step(1'b0, 5'd3, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 5'd3, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        // x0 destination never stalls.
        step(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        // Branch wins over a simultaneous load-use.
        step(1'b0, 5'd7, 5'd1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        // Three-cycle memory wait with a branch held in EX, then release.
        for (int unsigned i = 0; i < 3; i++)
            step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        // Store never completes: lock into the error state.
        for (int unsigned i = 0; i < 24; i++)
            step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("timeout_sticky", 32'(timeout_err), 32'd1);
        check("dmem_req_locked", 32'(dmem_req), 32'd0);
        idle(1'b1);
        idle(1'b0);
        check("after_err_reset", 32'(dut_ctrl()), 32'd0);
        // Reset in the middle of a wait.
        step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1'b0);

        // Randomized traffic; alternate between fast and slow memory phases.
        slow = 0;
        for (int unsigned i = 0; i < 800; i++) begin
            if (i % 60 == 0) slow = $urandom_range(0, 1);
            step(($urandom_range(0, 39) == 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) == 0), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                 slow != 0 ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 2) != 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
